// File: rtl/flit_ejector.sv
// Network-adapter receive side: checks flit destination, strips the header and queues payloads for the core.
// Optional build macro FLIT_EJECTOR_PARITY_EN adds even-parity checking over the whole flit (header[0] = parity bit).
module flit_ejector #(
  parameter int message_size  = 32,
  parameter int address_size  = 4,
  parameter int header_size   = 8,
  parameter int flit_size     = 40,
  parameter int fifo_depth    = 4,
  parameter int drop_cnt_size = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [address_size-1:0]  local_address,
  input  logic [flit_size-1:0]     flit_in,
  input  logic                     flit_valid,
  output logic                     flit_ready,
  output logic [message_size-1:0]  message_out,
  output logic                     message_valid,
  input  logic                     message_ready,
  output logic [drop_cnt_size-1:0] drop_count
`ifdef FLIT_EJECTOR_PARITY_EN
  ,
  output logic                     parity_err
`endif
);

  localparam int ptr_w = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;

  localparam logic [ptr_w-1:0]         ptr_one    = ptr_w'(1);
  localparam logic [ptr_w:0]           cnt_one    = (ptr_w + 1)'(1);
  localparam logic [ptr_w:0]           full_count = (ptr_w + 1)'(fifo_depth);
  localparam logic [drop_cnt_size-1:0] drop_one   = drop_cnt_size'(1);

  logic [message_size-1:0]  r_mem [fifo_depth];
  logic [ptr_w-1:0]         r_wr_ptr;
  logic [ptr_w-1:0]         r_rd_ptr;
  logic [ptr_w:0]           r_count;
  logic [drop_cnt_size-1:0] r_drop_count;

  logic w_accept;
  logic w_addr_match;
  logic w_flit_bad;
  logic w_push;
  logic w_drop;
  logic w_pop;

  // The destination field sits in the top bits of the header, which are the top bits of the flit.
  assign w_addr_match = (flit_in[flit_size-1 -: address_size] == local_address);

`ifdef FLIT_EJECTOR_PARITY_EN
  logic r_parity_err;
  logic w_parity_bad;

  assign w_parity_bad = ^flit_in;
  assign w_flit_bad   = w_parity_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_parity_err <= 1'b0;
    else        r_parity_err <= w_accept && w_parity_bad;
  end

  assign parity_err = r_parity_err;
`else
  logic w_unused_rsvd;

  assign w_unused_rsvd = ^flit_in[message_size +: (header_size - address_size)];
  assign w_flit_bad    = 1'b0;
`endif

  assign flit_ready    = (r_count != full_count);
  assign message_valid = (r_count != '0);
  assign message_out   = message_valid ? r_mem[r_rd_ptr] : '0;

  assign w_accept = flit_valid && flit_ready;
  assign w_push   = w_accept && w_addr_match && !w_flit_bad;
  assign w_drop   = w_accept && !w_push;
  assign w_pop    = message_valid && message_ready;

  // NOTE: payload storage has no reset; message_valid gates every read, so stale contents never escape.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= flit_in[message_size-1:0];
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + ptr_one;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + ptr_one;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + cnt_one;
        2'b01:   r_count <= r_count - cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

  // Saturates instead of wrapping so a flood of misrouted flits stays visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              r_drop_count <= '0;
    else if (w_drop && (r_drop_count != '1)) r_drop_count <= r_drop_count + drop_one;
  end

  assign drop_count = r_drop_count;

endmodule

// File: tb/tb_flit_ejector.sv
// Directed self-checking bench for flit_ejector: delivery, backpressure, drops, streaming, async reset
// and (when FLIT_EJECTOR_PARITY_EN is defined) parity rejection.
module tb_flit_ejector;

  logic        clk;
  logic        rst_n;
  logic [3:0]  local_address;
  logic [39:0] flit_in;
  logic        flit_valid;
  logic        flit_ready;
  logic [31:0] message_out;
  logic        message_valid;
  logic        message_ready;
  logic [7:0]  drop_count;
`ifdef FLIT_EJECTOR_PARITY_EN
  logic        parity_err;
`endif

  int n_checks = 0;
  int n_errors = 0;

  flit_ejector dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .local_address (local_address),
    .flit_in       (flit_in),
    .flit_valid    (flit_valid),
    .flit_ready    (flit_ready),
    .message_out   (message_out),
    .message_valid (message_valid),
    .message_ready (message_ready),
    .drop_count    (drop_count)
`ifdef FLIT_EJECTOR_PARITY_EN
    ,
    .parity_err    (parity_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Builds {dest, reserved, message} with header[0] set for even parity over the whole flit.
  function automatic logic [39:0] mk(input logic [3:0] dest, input logic [31:0] msg);
    logic [39:0] f;
    f     = {dest, 4'h0, msg};
    f[32] = ^f;
    return f;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Producer must hold a flit steady while the ejector is not ready.
  logic        held;
  logic [39:0] held_flit;
  initial held = 1'b0;
  always @(negedge clk) begin
    if (rst_n && held) begin
      check("producer_hold_valid", {63'd0, flit_valid}, 64'd1);
      check("producer_hold_flit", {24'd0, flit_in}, {24'd0, held_flit});
    end
    held      = rst_n && flit_valid && !flit_ready;
    held_flit = flit_in;
  end

  initial begin
    rst_n         = 1'b0;
    local_address = 4'h3;
    flit_in       = '0;
    flit_valid    = 1'b0;
    message_ready = 1'b0;
    #3;
    check("reset_flit_ready", {63'd0, flit_ready}, 64'd1);
    check("reset_msg_valid", {63'd0, message_valid}, 64'd0);
    check("reset_msg_out", {32'd0, message_out}, 64'd0);
    check("reset_drop_count", {56'd0, drop_count}, 64'd0);
    tick;
    tick;
    rst_n = 1'b1;
    tick;

    // Single matching flit: visible one cycle after accept, popped the next edge.
    flit_in       = mk(4'h3, 32'hDEADBEEF);
    flit_valid    = 1'b1;
    message_ready = 1'b1;
    check("single_pre_valid", {63'd0, message_valid}, 64'd0);
    tick;
    flit_valid = 1'b0;
    check("single_valid", {63'd0, message_valid}, 64'd1);
    check("single_out", {32'd0, message_out}, 64'hDEADBEEF);
    tick;
    check("single_popped_valid", {63'd0, message_valid}, 64'd0);
    check("single_popped_out", {32'd0, message_out}, 64'd0);
    check("single_popped_ready", {63'd0, flit_ready}, 64'd1);

    // Fill to depth 4 with the core stalled; the 5th flit is held off.
    message_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      flit_in    = mk(4'h3, 32'(i));
      flit_valid = 1'b1;
      tick;
    end
    check("full_ready_low", {63'd0, flit_ready}, 64'd0);
    check("full_head", {32'd0, message_out}, 64'd1);
    flit_in = mk(4'h3, 32'd5);
    tick;
    check("full_still_low", {63'd0, flit_ready}, 64'd0);
    check("full_head_held", {32'd0, message_out}, 64'd1);
    message_ready = 1'b1;
    tick;
    check("after_pop_ready", {63'd0, flit_ready}, 64'd1);
    check("order_2", {32'd0, message_out}, 64'd2);
    tick;
    flit_valid = 1'b0;
    check("order_3", {32'd0, message_out}, 64'd3);
    tick;
    check("order_4", {32'd0, message_out}, 64'd4);
    tick;
    check("order_5", {32'd0, message_out}, 64'd5);
    tick;
    check("drained_valid", {63'd0, message_valid}, 64'd0);

    // Misrouted flit is consumed and counted, never delivered.
    message_ready = 1'b0;
    flit_in       = mk(4'h5, 32'h12345678);
    flit_valid    = 1'b1;
    tick;
    flit_valid = 1'b0;
    check("drop_ready", {63'd0, flit_ready}, 64'd1);
    check("drop_no_valid", {63'd0, message_valid}, 64'd0);
    check("drop_count_1", {56'd0, drop_count}, 64'd1);
    flit_valid = 1'b1;
    repeat (253) tick;
    check("drop_count_fe", {56'd0, drop_count}, 64'hFE);
    repeat (47) tick;
    flit_valid = 1'b0;
    check("drop_count_sat", {56'd0, drop_count}, 64'hFF);
    check("drop_sat_no_valid", {63'd0, message_valid}, 64'd0);

    // Simultaneous push and pop at count 2 keeps two entries buffered.
    flit_in    = mk(4'h3, 32'hA1);
    flit_valid = 1'b1;
    tick;
    flit_in = mk(4'h3, 32'hA2);
    tick;
    check("pp_head_a1", {32'd0, message_out}, 64'hA1);
    flit_in       = mk(4'h3, 32'hA3);
    message_ready = 1'b1;
    tick;
    flit_valid = 1'b0;
    check("pp_head_a2", {32'd0, message_out}, 64'hA2);
    tick;
    check("pp_head_a3", {32'd0, message_out}, 64'hA3);
    tick;
    check("pp_empty", {63'd0, message_valid}, 64'd0);

    // Full-rate streaming: each message appears the cycle after it is accepted.
    for (int i = 0; i < 100; i++) begin
      flit_in    = mk(4'h3, 32'hA500_0000 + 32'(i));
      flit_valid = 1'b1;
      tick;
      check($sformatf("stream_%0d", i), {31'd0, flit_ready, message_valid, message_out},
            {31'd0, 1'b1, 1'b1, 32'hA500_0000 + 32'(i)});
    end
    flit_valid = 1'b0;
    tick;
    check("stream_done", {63'd0, message_valid}, 64'd0);

    // Asynchronous reset with three entries buffered.
    message_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      flit_in    = mk(4'h3, 32'hC0 + 32'(i));
      flit_valid = 1'b1;
      tick;
    end
    flit_valid = 1'b0;
    check("prerst_valid", {63'd0, message_valid}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", {63'd0, message_valid}, 64'd0);
    check("async_rst_ready", {63'd0, flit_ready}, 64'd1);
    check("async_rst_drop", {56'd0, drop_count}, 64'd0);
    check("async_rst_out", {32'd0, message_out}, 64'd0);
    #2;
    rst_n = 1'b1;
    tick;
    check("post_rst_valid", {63'd0, message_valid}, 64'd0);

`ifdef FLIT_EJECTOR_PARITY_EN
    // Single flipped payload bit: dropped despite matching address.
    flit_in    = mk(4'h3, 32'h0F0F_0F0F) ^ 40'h1;
    flit_valid = 1'b1;
    tick;
    flit_valid = 1'b0;
    check("par_err_pulse", {63'd0, parity_err}, 64'd1);
    check("par_no_valid", {63'd0, message_valid}, 64'd0);
    check("par_drop_count", {56'd0, drop_count}, 64'd1);
    tick;
    check("par_err_cleared", {63'd0, parity_err}, 64'd0);
    flit_in    = mk(4'h3, 32'h0F0F_0F0F);
    flit_valid = 1'b1;
    tick;
    flit_valid = 1'b0;
    check("par_ok_err", {63'd0, parity_err}, 64'd0);
    check("par_ok_out", {31'd0, message_valid, message_out}, {31'd0, 1'b1, 32'h0F0F_0F0F});
    check("par_ok_drop", {56'd0, drop_count}, 64'd1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
